// File: rtl/signal_monitor.sv
// signal_monitor: conflict monitor on the signal_vm lights; latches the first violation and requests flash.
// Ports: clk, rst_n (async active-low); Ago/Astop/Bgo/Bstop light inputs; fault_clr release pulse;
//        fault latched indicator; fault_code 0 none,1 CONFLICT,2 INVALID,3 CLEAR,4 MIN_GO,5 STUCK;
//        flash toggling request while faulted.
// Option: SIGNAL_MONITOR_COUNT_EN adds phase_count[15:0], legal go->all-stop exits, saturating.
module signal_monitor #(
  parameter int MIN_GO    = 4,
  parameter int MAX_GO    = 64,
  parameter int CLEAR     = 2,
  parameter int FLASH_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Ago,
  input  logic        Astop,
  input  logic        Bgo,
  input  logic        Bstop,
  input  logic        fault_clr,
  output logic        fault,
  output logic [2:0]  fault_code,
`ifdef SIGNAL_MONITOR_COUNT_EN
  output logic [15:0] phase_count,
`endif
  output logic        flash
);
  typedef enum logic [2:0] {IDLE, A_GO, B_GO, ALL_STOP, FAULT} state_t;
  state_t      r_state;
  logic        r_ago, r_astop, r_bgo, r_bstop;
  logic [15:0] r_go_cnt, r_clr_cnt, r_flash_cnt;
  logic        w_conflict, w_invalid, w_stop, w_in_go, w_go_ok, w_clr_ok, w_swap, w_stuck;
  logic [2:0]  w_code;
  always_comb begin
    w_conflict = r_ago & r_bgo;
    w_invalid  = ~(r_ago ^ r_astop) | ~(r_bgo ^ r_bstop);
    w_stop     = ~r_ago & ~r_bgo;
    w_in_go    = (r_state == A_GO) | (r_state == B_GO);
    w_go_ok    = r_go_cnt >= 16'(MIN_GO);
    w_clr_ok   = r_clr_cnt >= 16'(CLEAR);
    w_swap     = (r_state == A_GO && r_bgo) || (r_state == B_GO && r_ago);
    w_stuck    = ((r_state == A_GO && r_ago) || (r_state == B_GO && r_bgo)) && r_go_cnt == 16'(MAX_GO);
    w_code     = w_conflict ? 3'd1 :
                 w_invalid ? 3'd2 :
                 (r_state == ALL_STOP && !w_stop && !w_clr_ok) || w_swap ? 3'd3 :
                 (w_in_go && w_stop && !w_go_ok) ? 3'd4 :
                 w_stuck ? 3'd5 : 3'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ago       <= 1'b0;
      r_astop     <= 1'b1;
      r_bgo       <= 1'b0;
      r_bstop     <= 1'b1;
      r_go_cnt    <= '0;
      r_clr_cnt   <= '0;
      r_flash_cnt <= '0;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      flash       <= 1'b0;
`ifdef SIGNAL_MONITOR_COUNT_EN
      phase_count <= '0;
`endif
    end else begin
      {r_ago, r_astop, r_bgo, r_bstop} <= {Ago, Astop, Bgo, Bstop};
      if (r_state == FAULT) begin
        // release only once the sampled lights are a legal all-stop; no memory of earlier requests
        if (fault_clr && w_stop && !w_invalid) begin
          r_state    <= ALL_STOP;
          r_clr_cnt  <= '0;
          fault      <= 1'b0;
          fault_code <= 3'd0;
          flash      <= 1'b0;
        end else if (r_flash_cnt == 16'(FLASH_DIV - 1)) begin
          flash       <= ~flash;
          r_flash_cnt <= '0;
        end else begin
          r_flash_cnt <= r_flash_cnt + 16'd1;
        end
      end else if (w_code != 3'd0) begin
        r_state     <= FAULT;
        fault       <= 1'b1;
        fault_code  <= w_code;
        flash       <= 1'b1;
        r_flash_cnt <= '0;
      end else if (w_stop) begin
        r_state   <= ALL_STOP;
        r_clr_cnt <= r_state != ALL_STOP ? 16'd1 : w_clr_ok ? r_clr_cnt : r_clr_cnt + 16'd1;
`ifdef SIGNAL_MONITOR_COUNT_EN
        if (w_in_go && phase_count != 16'hFFFF) phase_count <= phase_count + 16'd1;
`endif
      end else begin
        r_state  <= r_ago ? A_GO : B_GO;
        r_go_cnt <= !w_in_go ? 16'd1 : r_go_cnt == 16'(MAX_GO) ? r_go_cnt : r_go_cnt + 16'd1;
      end
    end
  end
endmodule
